// File: rtl/mem_stage.sv
// Memory stage: retires ALU results and runs LW/LBU/SW/SB accesses on the data-memory port.
// Latency: 1 cycle for non-memory/misaligned ops, >= 2 cycles for memory ops (ack or timeout).
// Backpressure: ex_ready_o low while a memory access is outstanding; writeback has none.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic [2:0]  ex_mem_op_i,
    input  logic [31:0] ex_result_i,
    input  logic [31:0] ex_addr_i,
    input  logic        ex_we_i,
    input  logic [4:0]  ex_reg_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        wb_valid_o,
    output logic        wb_we_o,
    output logic [4:0]  wb_reg_o,
    output logic [31:0] wb_data_o,
    output logic        wb_err_o
);

    localparam logic [2:0]  OP_LW    = 3'd1;
    localparam logic [2:0]  OP_LBU   = 3'd2;
    localparam logic [2:0]  OP_SW    = 3'd3;
    localparam logic [2:0]  OP_SB    = 3'd4;
    // Last timer value before expiry; the abort edge is the one that would make the timer hit TIMEOUT_CYCLES.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  lane_q, lane_d;
    logic        rwe_q, rwe_d;
    logic [4:0]  rreg_q, rreg_d;
    logic        req_q, req_d;
    logic        dwe_q, dwe_d;
    logic [31:0] daddr_q, daddr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wbv_q, wbv_d;
    logic        wbwe_q, wbwe_d;
    logic [4:0]  wbreg_q, wbreg_d;
    logic [31:0] wbdata_q, wbdata_d;
    logic        wberr_q, wberr_d;

    logic        accept;
    logic        is_mem;
    logic        is_word;
    logic        misaligned;
    logic        ack_now;
    logic        timeout_now;
    logic        load_q;
    logic [7:0]  lane_byte;

    assign accept      = ex_valid_i && (state_q == S_IDLE);
    assign is_mem      = (ex_mem_op_i >= OP_LW) && (ex_mem_op_i <= OP_SB);
    assign is_word     = (ex_mem_op_i == OP_LW) || (ex_mem_op_i == OP_SW);
    assign misaligned  = is_word && (ex_addr_i[1:0] != 2'b00);
    assign ack_now     = (state_q == S_ACCESS) && dmem_ack_i;
    assign timeout_now = (state_q == S_ACCESS) && !dmem_ack_i && (timer_q == TMO_LAST);
    assign load_q      = (op_q == OP_LW) || (op_q == OP_LBU);

    // State register; reset mid-access discards the in-flight instruction.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: legal memory ops enter ACCESS, ack or expiry returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept && is_mem && !misaligned) state_d = S_ACCESS;
            S_ACCESS: if (dmem_ack_i || (timer_q == TMO_LAST)) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Upstream handshake depends on state only.
    always_comb begin
        ex_ready_o = (state_q == S_IDLE);
    end

    // Little-endian byte lane selection for LBU.
    always_comb begin
        lane_byte = dmem_rdata_i[7:0];
        case (lane_q)
            2'd0: lane_byte = dmem_rdata_i[7:0];
            2'd1: lane_byte = dmem_rdata_i[15:8];
            2'd2: lane_byte = dmem_rdata_i[23:16];
            2'd3: lane_byte = dmem_rdata_i[31:24];
            default: lane_byte = dmem_rdata_i[7:0];
        endcase
    end

    // Datapath next-state: request setup on accept, retirement on ack/expiry/non-memory op.
    always_comb begin
        timer_d  = timer_q;
        op_d     = op_q;
        lane_d   = lane_q;
        rwe_d    = rwe_q;
        rreg_d   = rreg_q;
        req_d    = req_q;
        dwe_d    = dwe_q;
        daddr_d  = daddr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        wbv_d    = 1'b0;
        wbwe_d   = wbwe_q;
        wbreg_d  = wbreg_q;
        wbdata_d = wbdata_q;
        wberr_d  = wberr_q;
        if (accept) begin
            if (!is_mem) begin
                wbv_d    = 1'b1;
                wbwe_d   = ex_we_i;
                wbreg_d  = ex_reg_i;
                wbdata_d = ex_result_i;
                wberr_d  = 1'b0;
            end else if (misaligned) begin
                wbv_d    = 1'b1;
                wbwe_d   = 1'b0;
                wbreg_d  = ex_reg_i;
                wbdata_d = 32'd0;
                wberr_d  = 1'b1;
            end else begin
                req_d   = 1'b1;
                daddr_d = {ex_addr_i[31:2], 2'b00};
                be_d    = is_word ? 4'b1111 : (4'b0001 << ex_addr_i[1:0]);
                dwe_d   = (ex_mem_op_i == OP_SW) || (ex_mem_op_i == OP_SB);
                if (ex_mem_op_i == OP_SW) begin
                    wdata_d = ex_result_i;
                end else if (ex_mem_op_i == OP_SB) begin
                    wdata_d = {4{ex_result_i[7:0]}};
                end else begin
                    wdata_d = 32'd0;
                end
                op_d    = ex_mem_op_i;
                lane_d  = ex_addr_i[1:0];
                rwe_d   = ex_we_i;
                rreg_d  = ex_reg_i;
                timer_d = 16'd0;
            end
        end else if (ack_now) begin
            req_d   = 1'b0;
            wbv_d   = 1'b1;
            wberr_d = 1'b0;
            wbreg_d = rreg_q;
            wbwe_d  = load_q ? rwe_q : 1'b0;
            if (op_q == OP_LW) begin
                wbdata_d = dmem_rdata_i;
            end else if (op_q == OP_LBU) begin
                wbdata_d = {24'd0, lane_byte};
            end else begin
                wbdata_d = 32'd0;
            end
        end else if (timeout_now) begin
            req_d    = 1'b0;
            wbv_d    = 1'b1;
            wberr_d  = 1'b1;
            wbwe_d   = 1'b0;
            wbreg_d  = rreg_q;
            wbdata_d = 32'd0;
        end else if (state_q == S_ACCESS) begin
            timer_d = timer_q + 16'd1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            timer_q  <= 16'd0;
            op_q     <= 3'd0;
            lane_q   <= 2'd0;
            rwe_q    <= 1'b0;
            rreg_q   <= 5'd0;
            req_q    <= 1'b0;
            dwe_q    <= 1'b0;
            daddr_q  <= 32'd0;
            be_q     <= 4'd0;
            wdata_q  <= 32'd0;
            wbv_q    <= 1'b0;
            wbwe_q   <= 1'b0;
            wbreg_q  <= 5'd0;
            wbdata_q <= 32'd0;
            wberr_q  <= 1'b0;
        end else begin
            timer_q  <= timer_d;
            op_q     <= op_d;
            lane_q   <= lane_d;
            rwe_q    <= rwe_d;
            rreg_q   <= rreg_d;
            req_q    <= req_d;
            dwe_q    <= dwe_d;
            daddr_q  <= daddr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            wbv_q    <= wbv_d;
            wbwe_q   <= wbwe_d;
            wbreg_q  <= wbreg_d;
            wbdata_q <= wbdata_d;
            wberr_q  <= wberr_d;
        end
    end

    assign dmem_req_o   = req_q;
    assign dmem_we_o    = dwe_q;
    assign dmem_addr_o  = daddr_q;
    assign dmem_be_o    = be_q;
    assign dmem_wdata_o = wdata_q;
    assign wb_valid_o   = wbv_q;
    assign wb_we_o      = wbwe_q;
    assign wb_reg_o     = wbreg_q;
    assign wb_data_o    = wbdata_q;
    assign wb_err_o     = wberr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: transaction-level timeline model checked every cycle, plus literal pins.
// The model plans each instruction's cycle-by-cycle outputs from the stage's rules.
// Memory acks are scheduled by the bench itself, including no-ack timeouts.
module tb_mem_stage;
    localparam int T    = 4;
    localparam int MAXC = 4096;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic [2:0]  ex_mem_op_i;
    logic [31:0] ex_result_i;
    logic [31:0] ex_addr_i;
    logic        ex_we_i;
    logic [4:0]  ex_reg_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o;
    logic        wb_we_o;
    logic [4:0]  wb_reg_o;
    logic [31:0] wb_data_o;
    logic        wb_err_o;

    mem_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .n_reset(n_reset),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_mem_op_i(ex_mem_op_i),
        .ex_result_i(ex_result_i), .ex_addr_i(ex_addr_i), .ex_we_i(ex_we_i), .ex_reg_i(ex_reg_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i),
        .dmem_rdata_i(dmem_rdata_i), .wb_valid_o(wb_valid_o), .wb_we_o(wb_we_o),
        .wb_reg_o(wb_reg_o), .wb_data_o(wb_data_o), .wb_err_o(wb_err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        busy;
        logic        req;
        logic        req_we;
        logic [31:0] req_addr;
        logic [3:0]  req_be;
        logic [31:0] req_wdata;
        logic        vld;
        logic        wb_we;
        logic        wb_err;
        logic        chk_data;
        logic [31:0] wb_data;
        logic        chk_reg;
        logic [4:0]  wb_reg;
    } exp_t;

    exp_t tl [MAXC];
    int   n_pass  = 0;
    int   n_total = 0;
    bit   chk_en  = 1'b0;

    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    endtask

    // Per-cycle comparison against the planned timeline.
    always @(negedge clk) begin : cmp
        exp_t e;
        if (chk_en && cyc < MAXC) begin
            e = tl[cyc];
            chk("ex_ready", ex_ready_o, !e.busy);
            chk("dmem_req", dmem_req_o, e.req);
            chk("wb_valid", wb_valid_o, e.vld);
            if (e.req) begin
                chk("dmem_we", dmem_we_o, e.req_we);
                chk("dmem_addr", dmem_addr_o, e.req_addr);
                chk("dmem_be", dmem_be_o, e.req_be);
                if (e.req_we) chk("dmem_wdata", dmem_wdata_o, e.req_wdata);
            end
            if (e.vld) begin
                chk("wb_we", wb_we_o, e.wb_we);
                chk("wb_err", wb_err_o, e.wb_err);
                if (e.chk_data) chk("wb_data", wb_data_o, e.wb_data);
                if (e.chk_reg) chk("wb_reg", wb_reg_o, e.wb_reg);
            end
        end
    end

    task automatic junk_inputs();
        ex_mem_op_i  = 3'($urandom);
        ex_result_i  = $urandom;
        ex_addr_i    = $urandom;
        ex_we_i      = 1'($urandom);
        ex_reg_i     = 5'($urandom);
        dmem_rdata_i = $urandom;
    endtask

    // Idle cycles with random (ignored) ack noise.
    task automatic idle(input int n, input bit force_ack);
        for (int i = 0; i < n; i++) begin
            ex_valid_i = 1'b0;
            junk_inputs();
            dmem_ack_i = force_ack ? 1'b1 : 1'($urandom);
            @(posedge clk); #1;
        end
        dmem_ack_i = 1'b0;
    endtask

    // Issue one instruction; d = access cycle carrying ack (d > T means never acked).
    // Returns #1 after the retirement edge.
    task automatic run_txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] res,
                           input logic we, input logic [4:0] rg, input int d, input logic [31:0] rdata);
        int   e_cyc, k;
        bit   mem, mis, load, store;
        exp_t e;
        e_cyc = cyc + 1;
        if (e_cyc + T + 4 >= MAXC) begin
            $display("FAIL timeline_overflow cyc=%0d", cyc);
            $fatal(1);
        end
        mem   = (op >= 3'd1) && (op <= 3'd4);
        load  = (op == 3'd1) || (op == 3'd2);
        store = (op == 3'd3) || (op == 3'd4);
        mis   = ((op == 3'd1) || (op == 3'd3)) && (addr % 4 != 0);
        ex_valid_i   = 1'b1;
        ex_mem_op_i  = op;
        ex_addr_i    = addr;
        ex_result_i  = res;
        ex_we_i      = we;
        ex_reg_i     = rg;
        dmem_ack_i   = 1'($urandom);
        dmem_rdata_i = $urandom;
        if (!mem || mis) begin
            e = '0;
            e.vld      = 1'b1;
            e.wb_we    = mem ? 1'b0 : we;
            e.wb_err   = mis;
            e.chk_data = !mis;
            e.wb_data  = res;
            e.chk_reg  = !mis;
            e.wb_reg   = rg;
            tl[e_cyc]  = e;
            @(posedge clk); #1;
            ex_valid_i = 1'b0;
            dmem_ack_i = 1'b0;
            return;
        end
        k = (d <= T) ? d : T;
        for (int i = 0; i < k; i++) begin
            e = '0;
            e.busy      = 1'b1;
            e.req       = 1'b1;
            e.req_we    = store;
            e.req_addr  = addr - (addr % 4);
            e.req_be    = (op == 3'd1 || op == 3'd3) ? 4'hF : 4'(1 << (addr % 4));
            e.req_wdata = (op == 3'd3) ? res : {24'd0, res[7:0]} * 32'h01010101;
            tl[e_cyc + i] = e;
        end
        e = '0;
        e.vld      = 1'b1;
        e.wb_err   = (d > T);
        e.wb_we    = (d <= T) && load && we;
        e.chk_data = (d <= T);
        e.wb_data  = (op == 3'd1) ? rdata :
                     (op == 3'd2) ? ((rdata >> (8 * (addr % 4))) & 32'hFF) : 32'd0;
        e.chk_reg  = load && (d <= T);
        e.wb_reg   = rg;
        tl[e_cyc + k] = e;
        @(posedge clk); #1;
        cap_addr  = dmem_addr_o;
        cap_wdata = dmem_wdata_o;
        cap_be    = dmem_be_o;
        cap_we    = dmem_we_o;
        ex_valid_i = 1'b0;
        junk_inputs();
        for (int i = 1; i <= k; i++) begin
            dmem_ack_i   = (i == d);
            dmem_rdata_i = (i == d) ? rdata : $urandom;
            @(posedge clk); #1;
        end
        dmem_ack_i = 1'b0;
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] addr;
        for (int i = 0; i < MAXC; i++) tl[i] = '0;
        n_reset    = 1'b1;
        ex_valid_i = 1'b0;
        dmem_ack_i = 1'b0;
        junk_inputs();
        #2 n_reset = 1'b0;
        #1;
        chk("rst_ready", ex_ready_o, 1'b1);
        chk("rst_req", dmem_req_o, 1'b0);
        chk("rst_dwe", dmem_we_o, 1'b0);
        chk("rst_addr", dmem_addr_o, 32'd0);
        chk("rst_be", dmem_be_o, 4'd0);
        chk("rst_wdata", dmem_wdata_o, 32'd0);
        chk("rst_valid", wb_valid_o, 1'b0);
        chk("rst_wbwe", wb_we_o, 1'b0);
        chk("rst_reg", wb_reg_o, 5'd0);
        chk("rst_data", wb_data_o, 32'd0);
        chk("rst_err", wb_err_o, 1'b0);
        #19 n_reset = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // Back-to-back non-memory ops.
        run_txn(3'd0, 32'h0, 32'h11, 1'b1, 5'd1, 0, 32'h0);
        chk("none1_data", wb_data_o, 32'h11);
        chk("none1_reg", wb_reg_o, 5'd1);
        run_txn(3'd0, 32'h4, 32'h22, 1'b1, 5'd2, 0, 32'h0);
        chk("none2_data", wb_data_o, 32'h22);
        run_txn(3'd6, 32'h8, 32'h33, 1'b1, 5'd3, 0, 32'h0);
        chk("none3_data", wb_data_o, 32'h33);
        chk("none3_ready", ex_ready_o, 1'b1);
        idle(2, 1'b0);

        run_txn(3'd1, 32'h100, 32'h0, 1'b1, 5'd7, 3, 32'hDEADBEEF);
        chk("lw_be", cap_be, 4'hF);
        chk("lw_addr", cap_addr, 32'h100);
        chk("lw_data", wb_data_o, 32'hDEADBEEF);
        chk("lw_valid", wb_valid_o, 1'b1);

        run_txn(3'd2, 32'h103, 32'h0, 1'b1, 5'd8, 1, 32'h80FF0102);
        chk("lbu_be", cap_be, 4'b1000);
        chk("lbu_data", wb_data_o, 32'h00000080);

        run_txn(3'd4, 32'h101, 32'h123456AB, 1'b1, 5'd9, 2, 32'h0);
        chk("sb_be", cap_be, 4'b0010);
        chk("sb_wdata", cap_wdata, 32'hABABABAB);
        chk("sb_we", cap_we, 1'b1);
        chk("sb_wbwe", wb_we_o, 1'b0);

        run_txn(3'd3, 32'h102, 32'h55, 1'b0, 5'd10, 1, 32'h0);
        chk("sw_mis_err", wb_err_o, 1'b1);
        chk("sw_mis_req", dmem_req_o, 1'b0);

        run_txn(3'd1, 32'h200, 32'h0, 1'b1, 5'd11, T + 1, 32'h0);
        chk("tmo_err", wb_err_o, 1'b1);
        chk("tmo_we", wb_we_o, 1'b0);

        run_txn(3'd1, 32'h204, 32'h0, 1'b1, 5'd12, T, 32'hCAFEF00D);
        chk("ack_at_expiry_err", wb_err_o, 1'b0);
        chk("ack_at_expiry_data", wb_data_o, 32'hCAFEF00D);

        idle(3, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 250; n++) begin
            op   = 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            run_txn(op, addr, $urandom, 1'($urandom), 5'($urandom), $urandom_range(1, T + 2), $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2), 1'b0);
        end
        idle(2, 1'b0);

        // Reset during an outstanding access.
        chk_en = 1'b0;
        ex_valid_i  = 1'b1;
        ex_mem_op_i = 3'd1;
        ex_addr_i   = 32'h300;
        ex_we_i     = 1'b1;
        ex_reg_i    = 5'd4;
        dmem_ack_i  = 1'b0;
        @(posedge clk); #1;
        ex_valid_i = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_req", dmem_req_o, 1'b1);
        #2 n_reset = 1'b0;
        #1;
        chk("mid_rst_req", dmem_req_o, 1'b0);
        chk("mid_rst_valid", wb_valid_o, 1'b0);
        chk("mid_rst_ready", ex_ready_o, 1'b1);
        @(negedge clk);
        @(negedge clk);
        n_reset = 1'b1;
        dmem_ack_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stray_ack_valid", wb_valid_o, 1'b0);
            chk("stray_ack_req", dmem_req_o, 1'b0);
        end
        dmem_ack_i = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
